// File: rtl/quant_dequantizer_if.sv
// Request/result handshake bundle for the serial dequantizer.
// The master side issues codes and consumes activations; the slave side is the dequantizer.
interface quant_dequantizer_if #(
   parameter int IDX_W  = 8,
   parameter int DATA_W = 32
);
   logic              i_valid;
   logic              o_ready;
   logic [IDX_W-1:0]  i_index;
   logic [DATA_W-1:0] i_unit;
   logic              o_valid;
   logic              i_ready;
   logic [DATA_W-1:0] o_activation;
   logic              o_ovf;

   modport master (
      output i_valid, i_index, i_unit, i_ready,
      input  o_ready, o_valid, o_activation, o_ovf
   );

   modport slave (
      input  i_valid, i_index, i_unit, i_ready,
      output o_ready, o_valid, o_activation, o_ovf
   );
endinterface

// File: rtl/quant_dequantizer.sv
// Serial dequantizer: rebuilds an activation from an index code by summing unit>>k
// for every set code bit, MSB first, one bit per clock, with saturation on overflow.
module quant_dequantizer #(
   parameter int IDX_W  = 8,
   parameter int DATA_W = 32
) (
   input logic                clk,
   input logic                rst,
   quant_dequantizer_if.slave bus
);
   localparam int CNT_W = (IDX_W > 1) ? $clog2(IDX_W) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(IDX_W - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_q;
   logic [IDX_W-1:0]  index_q;
   logic [DATA_W-1:0] unit_q;
   logic [DATA_W:0]   acc_q;
   logic [DATA_W:0]   acc_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] act_q;
   logic              ovf_q;

   function automatic logic [DATA_W-1:0] sat_out(input logic [DATA_W:0] acc);
      return acc[DATA_W] ? {DATA_W{1'b1}} : acc[DATA_W-1:0];
   endfunction

   // Extra accumulator bit holds the carry; the sum stays below 2*unit so it never wraps.
   always_comb begin
      acc_d = acc_q;
      if (index_q[IDX_W-1]) acc_d = acc_q + {1'b0, unit_q};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         index_q <= '0;
         unit_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         act_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.i_valid) begin
                  index_q <= bus.i_index;
                  unit_q  <= bus.i_unit;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               acc_q   <= acc_d;
               unit_q  <= unit_q >> 1;
               index_q <= index_q << 1;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST) begin
                  act_q   <= sat_out(acc_d);
                  ovf_q   <= acc_d[DATA_W];
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (bus.i_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.o_ready      = (state_q == IDLE);
   assign bus.o_valid      = (state_q == DONE);
   assign bus.o_activation = act_q;
   assign bus.o_ovf        = ovf_q;
endmodule

// File: tb/tb_quant_dequantizer.sv
// Bench for quant_dequantizer: directed table, handshake corner sequences and
// randomized codes checked against a plain-arithmetic reconstruction model.
module tb_quant_dequantizer;
   localparam int IDX_W  = 8;
   localparam int DATA_W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   quant_dequantizer_if #(.IDX_W(IDX_W), .DATA_W(DATA_W)) bus ();

   quant_dequantizer #(.IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int nvec  = 0;
   int nmiss = 0;

   typedef struct {
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] unit;
      logic [DATA_W-1:0] act;
      logic              ovf;
   } vec_t;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nmiss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Sum of truncated unit>>k over set code bits, MSB first.
   task automatic ref_model(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] unit,
                            output logic [DATA_W-1:0] act, output logic ovf);
      longint unsigned sum;
      sum = 0;
      for (int k = 0; k < IDX_W; k++)
         if (idx[IDX_W-1-k]) sum += longint'(unit) / (longint'(1) << k);
      ovf = (sum >= (longint'(1) << DATA_W));
      act = ovf ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
   endtask

   task automatic send(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] unit);
      logic rb;
      bit   ok;
      ok = 0;
      bus.i_valid = 1'b1;
      bus.i_index = idx;
      bus.i_unit  = unit;
      for (int c = 0; c < 100 && !ok; c++) begin
         rb = bus.o_ready;
         @(posedge clk); #1;
         if (rb) ok = 1;
      end
      bus.i_valid = 1'b0;
      if (!ok) check("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!bus.o_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_out();
      bus.i_ready = 1'b1;
      @(posedge clk); #1;
      bus.i_ready = 1'b0;
   endtask

   vec_t tbl[$];
   logic [IDX_W-1:0]  ridx;
   logic [DATA_W-1:0] runit, eact;
   logic              eovf;
   int                lat;

   initial begin
      bus.i_valid = 1'b0;
      bus.i_index = '0;
      bus.i_unit  = '0;
      bus.i_ready = 1'b0;

      tbl.push_back('{8'hC8, 32'd128,        32'd200,        1'b0});
      tbl.push_back('{8'hFF, 32'd5,          32'd8,          1'b0});
      tbl.push_back('{8'hA0, 32'd100,        32'd125,        1'b0});
      tbl.push_back('{8'hC0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1});
      tbl.push_back('{8'h80, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0});
      tbl.push_back('{8'h00, 32'd1234,       32'd0,          1'b0});
      tbl.push_back('{8'hFF, 32'd0,          32'd0,          1'b0});
      tbl.push_back('{8'hFF, 32'd128,        32'd255,        1'b0});
      tbl.push_back('{8'h01, 32'd128,        32'd1,          1'b0});
      tbl.push_back('{8'h40, 32'hFFFF_FFFF,  32'h7FFF_FFFF,  1'b0});

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_o_valid", 64'(bus.o_valid), 64'd0);
      check("rst_o_act",   64'(bus.o_activation), 64'd0);
      check("rst_o_ovf",   64'(bus.o_ovf), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_o_ready", 64'(bus.o_ready), 64'd1);

      // Directed table
      foreach (tbl[i]) begin
         send(tbl[i].idx, tbl[i].unit);
         wait_done(lat);
         check($sformatf("tbl%0d_latency", i), 64'(lat), 64'd8);
         check($sformatf("tbl%0d_act", i), 64'(bus.o_activation), 64'(tbl[i].act));
         check($sformatf("tbl%0d_ovf", i), 64'(bus.o_ovf), 64'(tbl[i].ovf));
         release_out();
      end

      // Backpressure: hold result 5 cycles while a new request waits
      send(8'hC8, 32'd128);
      wait_done(lat);
      check("bp_latency", 64'(lat), 64'd8);
      bus.i_valid = 1'b1;
      bus.i_index = 8'hA0;
      bus.i_unit  = 32'd100;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check("bp_o_valid", 64'(bus.o_valid), 64'd1);
         check("bp_o_act",   64'(bus.o_activation), 64'd200);
         check("bp_o_ovf",   64'(bus.o_ovf), 64'd0);
         check("bp_o_ready", 64'(bus.o_ready), 64'd0);
      end
      bus.i_ready = 1'b1;
      @(posedge clk); #1;
      bus.i_ready = 1'b0;
      check("bp_post_hs_valid", 64'(bus.o_valid), 64'd0);
      check("bp_post_hs_ready", 64'(bus.o_ready), 64'd1);
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      check("bp_reaccept", 64'(bus.o_ready), 64'd0);
      wait_done(lat);
      check("bp2_latency", 64'(lat), 64'd8);
      check("bp2_act", 64'(bus.o_activation), 64'd125);
      release_out();

      // Back-to-back with i_valid and i_ready held high
      begin
         int acc_n, rise_n;
         int rise_t[2];
         logic [DATA_W-1:0] rv[2];
         logic rb, pv;
         acc_n = 0; rise_n = 0; pv = 1'b0;
         rise_t[0] = 0; rise_t[1] = 0; rv[0] = '0; rv[1] = '0;
         bus.i_ready = 1'b1;
         bus.i_valid = 1'b1;
         bus.i_index = 8'hC8;
         bus.i_unit  = 32'd128;
         for (int c = 0; c < 60 && rise_n < 2; c++) begin
            rb = bus.o_ready;
            @(posedge clk); #1;
            if (rb && bus.i_valid) begin
               acc_n++;
               if (acc_n == 1) begin
                  bus.i_index = 8'hFF;
                  bus.i_unit  = 32'd5;
               end else begin
                  bus.i_valid = 1'b0;
               end
            end
            if (bus.o_valid && !pv) begin
               rise_t[rise_n] = c;
               rv[rise_n] = bus.o_activation;
               rise_n++;
            end
            pv = bus.o_valid;
         end
         bus.i_valid = 1'b0;
         check("b2b_results", 64'(rise_n), 64'd2);
         check("b2b_act0", 64'(rv[0]), 64'd200);
         check("b2b_act1", 64'(rv[1]), 64'd8);
         check("b2b_spacing", 64'(rise_t[1] - rise_t[0]), 64'd10);
         @(posedge clk); #1;
         bus.i_ready = 1'b0;
      end

      // Reset mid-RUN
      send(8'hFF, 32'd128);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rstrun_o_valid", 64'(bus.o_valid), 64'd0);
      check("rstrun_o_ready", 64'(bus.o_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      send(8'hFF, 32'd128);
      wait_done(lat);
      check("rstrun_latency", 64'(lat), 64'd8);
      check("rstrun_act", 64'(bus.o_activation), 64'd255);
      // Reset while holding a result drops o_valid without a clock edge
      #2;
      rst = 1'b1;
      #1;
      check("rstdone_o_valid", 64'(bus.o_valid), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Randomized codes with random downstream stalls
      for (int n = 0; n < 30; n++) begin
         int stall;
         ridx = IDX_W'($urandom);
         case ($urandom_range(0, 3))
            0: runit = $urandom;
            1: runit = 32'hFFFF_FFFF - $urandom_range(0, 255);
            2: runit = $urandom_range(0, 300);
            default: runit = 32'h8000_0000 | $urandom;
         endcase
         ref_model(ridx, runit, eact, eovf);
         stall = $urandom_range(0, 3);
         send(ridx, runit);
         wait_done(lat);
         check($sformatf("rnd%0d_latency", n), 64'(lat), 64'd8);
         repeat (stall) @(posedge clk);
         #1;
         check($sformatf("rnd%0d_act idx=%0h unit=%0h", n, ridx, runit),
               64'(bus.o_activation), 64'(eact));
         check($sformatf("rnd%0d_ovf", n), 64'(bus.o_ovf), 64'(eovf));
         release_out();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
      $finish;
   end
endmodule

// File: doc/quant_dequantizer.md
Name: quant_dequantizer

Overview:
- Inverse of the quantization divider chain: rebuilds an activation value from a quantized index code and the top-stage unit.
- Divider chain behaviour it mirrors: stage k compares against unit>>k and emits one index bit, MSB first.
- This block walks the same bit order serially, one bit per clock, accumulating unit>>k for every set bit, so a code round-trips exactly, including per-stage truncation.
- Sits on the dequantization path feeding the next CNN layer; valid/ready on both sides.

Parameters:
IDX_W, 8, index code width (number of iterations)
DATA_W, 32, unit/activation width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
i_valid  input  1  request valid
o_ready  output  1  block can accept a request (high only in IDLE)
i_index  input  IDX_W  quantized code, MSB = first divider stage
i_unit  input  DATA_W  unit of first divider stage
o_valid  output  1  result valid (high only in DONE)
i_ready  input  1  downstream accepts result
o_activation  output  DATA_W  reconstructed activation (saturated)
o_ovf  output  1  accumulation exceeded DATA_W bits; qualified by o_valid

Behaviour:
- Single clock clk. rst is asynchronous, active-high. On rst: state=IDLE, all internal registers=0, o_valid=0, o_activation=0, o_ovf=0. o_ready follows IDLE, so it reads 1 once rst deasserts.
- FSM states IDLE, RUN, DONE. o_ready = (state==IDLE). o_valid = (state==DONE).
- IDLE:
  - On i_valid && o_ready at edge T, capture r_index=i_index, r_unit=i_unit, r_acc=0 (DATA_W+1 bits), r_cnt=0. Go to RUN.
  - Inputs are not sampled otherwise.
- RUN, every edge:
  - If r_index[IDX_W-1]: r_acc <= r_acc + {1'b0,r_unit}.
  - r_unit <= r_unit>>1 (logical). r_index <= r_index<<1. r_cnt++.
  - On the edge where r_cnt==IDX_W-1 (the IDX_W-th step), go to DONE.
  - Steps occur at edges T+1..T+IDX_W. o_valid rises after edge T+IDX_W: latency IDX_W cycles from the accept edge (8 by default). No early exit on zero index or zero unit; latency is fixed.
- Arithmetic:
  - Result = sum over k=0..IDX_W-1 of index[IDX_W-1-k] * (unit>>k), each term truncated before adding. This is not (index*unit)>>(IDX_W-1).
  - r_acc is DATA_W+1 bits and cannot wrap, since the sum is < 2*unit.
  - o_ovf = r_acc[DATA_W].
  - o_activation = o_ovf ? all-ones : r_acc[DATA_W-1:0].
- DONE:
  - o_activation and o_ovf are driven from registers and held stable while o_valid && !i_ready.
  - On i_ready, go to IDLE. Result registers keep their value until the next accept.
  - No same-cycle re-accept: o_ready is low in DONE, so a new request is taken at the earliest one cycle after the output handshake.
- i_valid is ignored in RUN and DONE. Upstream must hold it until o_ready.
- Input edge cases:
  - i_unit=0 gives result 0 and ovf=0.
  - i_index=0 gives 0.
  - IDX_W=1 gives exactly one RUN step.
- rst asserted in RUN or DONE aborts immediately to IDLE. The partial result is discarded and o_valid drops asynchronously.

Test Plan:
- Round trip: i_index=8'hC8, i_unit=128 -> o_activation=200, o_ovf=0, o_valid exactly 8 cycles after accept. This matches the divider chain output for activation 200, unit 128.
- Truncation: i_index=8'hFF, i_unit=5 -> 5+2+1 = 8. Second case: i_index=8'hA0, i_unit=100 -> 100+25 = 125.
- Saturation: i_index=8'hC0, i_unit=32'hFFFF_FFFF -> sum 0x1_7FFF_FFFE, so o_activation=32'hFFFF_FFFF, o_ovf=1.
- Backpressure:
  - Hold i_ready=0 for 5 cycles in DONE -> o_valid, o_activation, o_ovf stable; o_ready=0.
  - A new i_valid during this window is not accepted. It is accepted the cycle after the output handshake.
- Back-to-back: two requests with i_valid held high -> second accept one cycle after the first output handshake; both results correct, spacing 10 cycles with i_ready=1.
- Reset mid-RUN: assert rst at step 4 -> o_valid=0, o_ready=1 after release. A fresh request (8'hFF, 128) returns 255.
